// File: rtl/bb_desc_pkg.sv
// ---------------------------------------------------------------------------
// bb_desc_pkg
// Shared definitions for the BBFRAME front end of the descrambler:
//   - sequencer state encoding (IDLE / RUN / GAP)
//   - DVB-S2 code rate index constants
//   - K_BCH tables for normal and short FECFRAMEs
//   - KBCH_INVALID sentinel used where a MODCOD does not exist
// ---------------------------------------------------------------------------
package bb_desc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } seq_state_e;

  // Code rate indices as presented on cfg_rate
  localparam logic [3:0] RATE_1_4  = 4'd0;
  localparam logic [3:0] RATE_1_3  = 4'd1;
  localparam logic [3:0] RATE_2_5  = 4'd2;
  localparam logic [3:0] RATE_1_2  = 4'd3;
  localparam logic [3:0] RATE_3_5  = 4'd4;
  localparam logic [3:0] RATE_2_3  = 4'd5;
  localparam logic [3:0] RATE_3_4  = 4'd6;
  localparam logic [3:0] RATE_4_5  = 4'd7;
  localparam logic [3:0] RATE_5_6  = 4'd8;
  localparam logic [3:0] RATE_8_9  = 4'd9;
  localparam logic [3:0] RATE_9_10 = 4'd10;
  localparam logic [3:0] RATE_MAX  = RATE_9_10;

  // A K_BCH of zero never describes a real frame, so it doubles as "no entry".
  localparam logic [15:0] KBCH_INVALID = 16'd0;

  // Smallest frame the sequencer can close (SOF beat plus one more bit).
  localparam logic [15:0] KBCH_MIN = 16'd2;

  // Tables are indexed by rate; entry 0 is the rightmost element.
  localparam logic [10:0][15:0] KBCH_NORMAL = {
    16'd58192, 16'd57472, 16'd53840, 16'd51648, 16'd48408, 16'd43040,
    16'd38688, 16'd32208, 16'd25728, 16'd21408, 16'd16008
  };

  // Short frames have no 9/10 code, hence the sentinel in the top slot.
  localparam logic [10:0][15:0] KBCH_SHORT = {
    KBCH_INVALID, 16'd14232, 16'd13152, 16'd12432, 16'd11712, 16'd10632,
    16'd9552,     16'd7032,  16'd6312,  16'd5232,  16'd3072
  };

endpackage

// File: rtl/bb_kbch_lut.sv
// ---------------------------------------------------------------------------
// bb_kbch_lut
// Combinational K_BCH lookup from FECFRAME size and code rate.
// Ports:
//   frame_short  in   0 = normal FECFRAME, 1 = short
//   rate         in   code rate index 0..10
//   kbch         out  K_BCH, KBCH_INVALID when the MODCOD does not exist
//   valid        out  1 when kbch names a real MODCOD
// ---------------------------------------------------------------------------
module bb_kbch_lut
  import bb_desc_pkg::*;
(
  input  logic        frame_short,
  input  logic [3:0]  rate,
  output logic [15:0] kbch,
  output logic        valid
);

  always_comb begin
    kbch = KBCH_INVALID;
    if (rate <= RATE_MAX) begin
      kbch = frame_short ? KBCH_SHORT[rate] : KBCH_NORMAL[rate];
    end
    // Out-of-range rates and short 9/10 both land on the sentinel.
    valid = (kbch != KBCH_INVALID);
  end

endmodule

// File: rtl/bb_frame_sequencer.sv
// ---------------------------------------------------------------------------
// bb_frame_sequencer
// Frame-level controller in front of the BB descrambler. Takes a bit-serial
// BBFRAME stream with an SOF marker, resolves K_BCH at SOF (lookup or test
// override), forwards bits with a one-cycle re-seed pulse on the first bit,
// closes the frame after exactly K_BCH bits and then holds off upstream for
// GAP_CYCLES cycles.
// Ports:
//   clk, rst                 clock / async active-high reset
//   s_bit, s_valid, s_sof    upstream beat, SOF qualified by s_valid
//   s_ready                  low only during the inter-frame gap
//   cfg_frame_short/rate     MODCOD used for the K_BCH lookup
//   cfg_override_en/kbch     test override of K_BCH
//   d_bit, d_valid           registered bit stream to the descrambler
//   d_kbch                   K_BCH of the current frame
//   d_frame_start            PRBS re-seed, with the first d_valid of a frame
//   frame_done               with the last d_valid of a frame
//   frame_cnt                completed frames, wrapping
//   err_modcod, err_trunc    bad config at SOF / SOF inside a frame
//   busy                     not idle
// ---------------------------------------------------------------------------
module bb_frame_sequencer
  import bb_desc_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_bit,
  input  logic             s_valid,
  input  logic             s_sof,
  output logic             s_ready,
  input  logic             cfg_frame_short,
  input  logic [3:0]       cfg_rate,
  input  logic             cfg_override_en,
  input  logic [15:0]      cfg_override_kbch,
  output logic             d_bit,
  output logic             d_valid,
  output logic [15:0]      d_kbch,
  output logic             d_frame_start,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             err_modcod,
  output logic             err_trunc,
  output logic             busy
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  seq_state_e        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [GAP_W-1:0]  gap, gap_n;
  logic [15:0]       kbch_n;
  logic [CNT_W-1:0]  fcnt_n;
  logic              d_bit_n, d_valid_n, start_n, done_n, errm_n, errt_n;

  logic [15:0]       lut_kbch;
  logic              lut_valid;
  logic [15:0]       sof_kbch;
  logic              sof_ok;
  logic              accept;
  logic              take_sof;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  kbch_cmp;

  bb_kbch_lut u_lut (
    .frame_short (cfg_frame_short),
    .rate        (cfg_rate),
    .kbch        (lut_kbch),
    .valid       (lut_valid)
  );

  // Config resolution happens every cycle but is only consumed on an SOF,
  // which is what makes mid-frame config changes harmless.
  assign sof_kbch = cfg_override_en ? cfg_override_kbch : lut_kbch;
  assign sof_ok   = cfg_override_en ? (cfg_override_kbch >= KBCH_MIN) : lut_valid;

  assign s_ready  = (state != ST_GAP);
  assign busy     = (state != ST_IDLE);
  assign accept   = s_valid & s_ready;
  assign cnt_inc  = cnt + CNT_W'(1);
  assign kbch_cmp = CNT_W'(d_kbch);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    gap_n     = gap;
    kbch_n    = d_kbch;
    fcnt_n    = frame_cnt;
    d_bit_n   = 1'b0;
    d_valid_n = 1'b0;
    start_n   = 1'b0;
    done_n    = 1'b0;
    errm_n    = 1'b0;
    errt_n    = 1'b0;
    take_sof  = 1'b0;

    case (state)
      ST_IDLE: begin
        // Non-SOF beats in IDLE are consumed and dropped.
        if (accept && s_sof) take_sof = 1'b1;
      end
      ST_RUN: begin
        if (accept) begin
          if (s_sof) begin
            // Truncated frame: report it, then restart from this beat.
            errt_n   = 1'b1;
            take_sof = 1'b1;
          end else begin
            d_valid_n = 1'b1;
            d_bit_n   = s_bit;
            cnt_n     = cnt_inc;
            if (cnt_inc == kbch_cmp) begin
              done_n  = 1'b1;
              fcnt_n  = frame_cnt + CNT_W'(1);
              gap_n   = GAP_W'(GAP_CYCLES);
              state_n = ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        // s_ready is low for exactly GAP_CYCLES cycles.
        if (gap == GAP_W'(1)) begin
          gap_n   = '0;
          state_n = ST_IDLE;
        end else begin
          gap_n = gap - GAP_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (take_sof) begin
      if (sof_ok) begin
        kbch_n    = sof_kbch;
        d_valid_n = 1'b1;
        d_bit_n   = s_bit;
        start_n   = 1'b1;
        cnt_n     = CNT_W'(1);
        state_n   = ST_RUN;
      end else begin
        errm_n  = 1'b1;
        state_n = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      gap           <= '0;
      d_kbch        <= '0;
      frame_cnt     <= '0;
      d_bit         <= 1'b0;
      d_valid       <= 1'b0;
      d_frame_start <= 1'b0;
      frame_done    <= 1'b0;
      err_modcod    <= 1'b0;
      err_trunc     <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      gap           <= gap_n;
      d_kbch        <= kbch_n;
      frame_cnt     <= fcnt_n;
      d_bit         <= d_bit_n;
      d_valid       <= d_valid_n;
      d_frame_start <= start_n;
      frame_done    <= done_n;
      err_modcod    <= errm_n;
      err_trunc     <= errt_n;
    end
  end

endmodule
